iob_eth_tx_frame_buffer: RTL

Transmit-side stage directly downstream of the CPU/non-DMA frame-word register path of the IOb Ethernet core. It captures frame bytes written one at a time by software (or by the simulation relay driver), holds them in a local byte buffer, and on a start command serialises preamble, SFD, data, optional zero padding, optional CRC-32 and the inter-frame gap onto a MII-style nibble interface. It sits between the register/descriptor logic (upstream) and the PHY pins (downstream).

---
 rtl/iob_eth_tx_frame_buffer_pkg.sv | 32 +++
 rtl/iob_eth_crc32.sv | 21 ++
 rtl/iob_ram_2p.sv | 23 ++
 rtl/iob_eth_tx_frame_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/iob_eth_tx_frame_buffer_pkg.sv
// Shared types and constants for the Ethernet TX frame buffer.
// Holds the FSM encoding, preamble/SFD nibbles and the CRC-32 step.
package iob_eth_tx_frame_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_CRC,
    ST_IFG
  } tx_state_t;

  localparam logic [3:0]  PRE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB  = 4'hD;
  localparam logic [7:0]  SFD_SLOT = 8'd15;
  localparam logic [7:0]  CRC_LAST = 8'd7;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/iob_eth_crc32.sv
// Byte-serial IEEE 802.3 CRC-32 register (reflected form).
// init_i reloads the seed; en_i folds one byte into the remainder.
module iob_eth_crc32
  import iob_eth_tx_frame_buffer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || init_i)
      crc_o <= CRC_INIT;
    else if (en_i)
      crc_o <= crc32_byte(crc_o, data_i);
  end

endmodule

// File: rtl/iob_ram_2p.sv
// Two-port RAM: one synchronous write port, one registered read port.
// Read data appears one clock after the address is presented.
module iob_ram_2p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              w_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (w_en_i) mem[w_addr_i] <= w_data_i;
    if (r_en_i) r_data_o <= mem[r_addr_i];
  end

endmodule

// File: rtl/iob_eth_tx_frame_buffer.sv
// Buffers software-written frame bytes and serialises them as an MII
// nibble stream with preamble, optional padding, CRC-32 and the IFG.
module iob_eth_tx_frame_buffer
  import iob_eth_tx_frame_buffer_pkg::*;
#(
  parameter int BUF_ADDR_W  = 11,
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_valid_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ready_o,
  input  logic [15:0] size_i,
  input  logic        crc_en_i,
  input  logic        pad_en_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        mii_tick_i,
  output logic        mii_tx_en_o,
  output logic [3:0]  mii_txd_o
);

  localparam logic [BUF_ADDR_W:0] CAP =
    {1'b1, {BUF_ADDR_W{1'b0}}};
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 1);

  tx_state_t st, st_nxt;

  logic [BUF_ADDR_W:0]   wr_ptr;
  logic [BUF_ADDR_W-1:0] rd_ptr;
  logic [15:0] size_q, bcnt;
  logic        crc_q, pad_q;
  logic [7:0]  cnt;
  logic        hi_q;
  logic [3:0]  hi_nib;
  logic [7:0]  rd_data, byte_val;
  logic [31:0] crc_val, crc_n;

  logic wr_fire, idle, start_ok, start_bad;
  logic txen, last, crc_upd, done_nxt;
  logic [3:0] nib;

  assign wr_ready_o = !busy_o && (wr_ptr != CAP);
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign idle       = (st == ST_IDLE) && !busy_o;
  assign start_ok   = start_i && idle && (size_i != 16'd0)
                   && (size_i <= 16'(wr_ptr));
  assign start_bad  = start_i && idle && !start_ok;
  assign byte_val   = (st == ST_PAD) ? 8'h00 : rd_data;
  assign crc_n      = ~crc_val;

  iob_ram_2p #(
    .DATA_W (8),
    .ADDR_W (BUF_ADDR_W)
  ) u_buf (
    .clk_i    (clk_i),
    .w_en_i   (wr_fire),
    .w_addr_i (wr_ptr[BUF_ADDR_W-1:0]),
    .w_data_i (wr_data_i),
    .r_en_i   (1'b1),
    .r_addr_i (rd_ptr),
    .r_data_o (rd_data)
  );

  iob_eth_crc32 u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (start_ok),
    .en_i   (crc_upd),
    .data_i (byte_val),
    .crc_o  (crc_val)
  );

  always_comb begin
    st_nxt   = st;
    nib      = 4'h0;
    txen     = 1'b0;
    last     = 1'b0;
    crc_upd  = 1'b0;
    done_nxt = 1'b0;
    unique case (st)
      ST_IDLE: if (start_ok) st_nxt = ST_PRE;
      ST_PRE: begin
        txen = 1'b1;
        last = (cnt == SFD_SLOT);
        nib  = last ? SFD_NIB : PRE_NIB;
        if (mii_tick_i && last) st_nxt = ST_DATA;
      end
      ST_DATA, ST_PAD: begin
        txen    = 1'b1;
        nib     = hi_q ? hi_nib : byte_val[3:0];
        crc_upd = mii_tick_i && !hi_q;
        last    = hi_q && (16'(bcnt + 16'd1) ==
                  ((st == ST_DATA) ? size_q : MIN_LEN));
        if (mii_tick_i && last) begin
          if (st == ST_DATA && pad_q && size_q < MIN_LEN)
            st_nxt = ST_PAD;
          else if (crc_q)
            st_nxt = ST_CRC;
          else
            st_nxt = ST_IFG;
        end
      end
      ST_CRC: begin
        txen = 1'b1;
        nib  = crc_n[{cnt[2:0], 2'b00} +: 4];
        last = (cnt == CRC_LAST);
        if (mii_tick_i && last) st_nxt = ST_IFG;
      end
      ST_IFG: begin
        last = (cnt == IFG_LAST);
        if (mii_tick_i && last) begin
          st_nxt   = ST_IDLE;
          done_nxt = 1'b1;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st          <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      size_q      <= '0;
      bcnt        <= '0;
      crc_q       <= 1'b0;
      pad_q       <= 1'b0;
      cnt         <= '0;
      hi_q        <= 1'b0;
      hi_nib      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mii_tx_en_o <= 1'b0;
      mii_txd_o   <= '0;
    end else begin
      st     <= st_nxt;
      err_o  <= start_bad;
      done_o <= done_nxt;
      if (start_ok)    busy_o <= 1'b1;
      else if (done_o) busy_o <= 1'b0;
      if (done_o)       wr_ptr <= '0;
      else if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (start_ok) begin
        size_q <= size_i;
        crc_q  <= crc_en_i;
        pad_q  <= pad_en_i;
        rd_ptr <= '0;
        bcnt   <= '0;
        hi_q   <= 1'b0;
      end
      if (mii_tick_i) begin
        mii_tx_en_o <= txen;
        mii_txd_o   <= nib;
        cnt <= (st != st_nxt) ? 8'd0 : cnt + 8'd1;
        // low nibble slot consumes the RAM byte; high half is replayed
        if (st == ST_DATA || st == ST_PAD) begin
          if (!hi_q) begin
            hi_nib <= byte_val[7:4];
            rd_ptr <= rd_ptr + 1'b1;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
          hi_q <= !hi_q;
        end
      end
      if (start_ok) cnt <= '0;
    end
  end

endmodule
